// File: rtl/shift_sequencer_if.sv
// Pixel-word and shift-register strobe bundle between the line buffer/timing side
// (master) and the shift sequencer (slave).
interface shift_sequencer_if;
  logic [1:0]  bpp_i;
  logic        hden_i;
  logic [15:0] wdat_i;
  logic        wvalid_i;
  logic        wack_o;
  logic [15:0] srdat_o;
  logic        load_o;
  logic        shift1_o;
  logic        shift2_o;
  logic        shift4_o;
  logic        shift8_o;
  logic        underrun_o;

  // Word handshake: wvalid_i says wdat_i is usable; wack_o pulses for exactly the
  // load cycle that consumes it, and a load with wvalid_i low is an underrun.
  modport master (
    output bpp_i, hden_i, wdat_i, wvalid_i,
    input  wack_o, srdat_o, load_o, shift1_o, shift2_o, shift4_o, shift8_o, underrun_o
  );

  modport slave (
    input  bpp_i, hden_i, wdat_i, wvalid_i,
    output wack_o, srdat_o, load_o, shift1_o, shift2_o, shift4_o, shift8_o, underrun_o
  );
endinterface

// File: rtl/shift_sequencer.sv
// Paces a pixel shift register: one load per word, then N-1 depth-specific shift
// strobes, N = 16 >> bpp, running only while horizontal display enable is high.
module shift_sequencer (
  input  logic                    dotclk_i,
  input  logic                    reset_i,
  shift_sequencer_if.slave        bus,
  output logic                    dbg_state_o,
  output logic [3:0]              dbg_phase_o
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_phase;
  logic [3:0]  w_phase_nxt;
  logic [1:0]  r_lbpp;
  logic [1:0]  w_lbpp_nxt;
  logic        r_underrun;
  logic        w_underrun_nxt;
  logic        w_load;
  logic [3:0]  w_last;

  always_ff @(posedge dotclk_i) begin
    if (reset_i) begin
      r_state    <= IDLE;
      r_phase    <= 4'd0;
      r_lbpp     <= 2'b00;
      r_underrun <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_phase    <= w_phase_nxt;
      r_lbpp     <= w_lbpp_nxt;
      r_underrun <= w_underrun_nxt;
    end
  end

  // Last phase of a word for the depth latched at its load cycle.
  always_comb begin
    w_last = 4'd15;
    case (r_lbpp)
      2'b00: w_last = 4'd15;
      2'b01: w_last = 4'd7;
      2'b10: w_last = 4'd3;
      2'b11: w_last = 4'd1;
      default: w_last = 4'd15;
    endcase
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_phase_nxt    = r_phase;
    w_lbpp_nxt     = r_lbpp;
    w_underrun_nxt = r_underrun;
    w_load         = 1'b0;
    bus.load_o     = 1'b0;
    bus.wack_o     = 1'b0;
    bus.srdat_o    = 16'h0000;
    bus.shift1_o   = 1'b0;
    bus.shift2_o   = 1'b0;
    bus.shift4_o   = 1'b0;
    bus.shift8_o   = 1'b0;

    case (r_state)
      IDLE: begin
        if (bus.hden_i) begin
          w_state_nxt = RUN;
          w_phase_nxt = 4'd0;
        end
      end
      RUN: begin
        w_load = (r_phase == 4'd0);
        if (w_load) begin
          bus.load_o = 1'b1;
          bus.wack_o = bus.wvalid_i;
          bus.srdat_o = bus.wvalid_i ? bus.wdat_i : 16'h0000;
          w_lbpp_nxt = bus.bpp_i;
          if (!bus.wvalid_i) w_underrun_nxt = 1'b1;
        end else begin
          bus.shift1_o = (r_lbpp == 2'b00);
          bus.shift2_o = (r_lbpp == 2'b01);
          bus.shift4_o = (r_lbpp == 2'b10);
          bus.shift8_o = (r_lbpp == 2'b11);
        end
        // Dropping hden_i abandons the rest of the word, even on a wrap edge.
        if (!bus.hden_i) begin
          w_state_nxt = IDLE;
          w_phase_nxt = 4'd0;
        end else if (w_load) begin
          w_phase_nxt = 4'd1;
        end else if (r_phase == w_last) begin
          w_phase_nxt = 4'd0;
        end else begin
          w_phase_nxt = r_phase + 4'd1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_phase_nxt = 4'd0;
      end
    endcase
  end

  assign bus.underrun_o = r_underrun;
  assign dbg_state_o    = r_state;
  assign dbg_phase_o    = r_phase;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed scenarios plus randomized
// traffic, every cycle compared against a word-position reference model.
module tb_shift_sequencer;

  logic        clk;
  logic        rst;
  logic        dbg_state;
  logic [3:0]  dbg_phase;
  int          n_checks;
  int          n_errors;

  logic [22:0] exp_q[$];

  // Reference model: where we are inside the current word, in pixels.
  bit          m_running;
  int          m_pos;
  int          m_word_bpp;
  bit          m_under;

  shift_sequencer_if sif();

  shift_sequencer dut (
    .dotclk_i    (clk),
    .reset_i     (rst),
    .bus         (sif.slave),
    .dbg_state_o (dbg_state),
    .dbg_phase_o (dbg_phase)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [22:0] obs, input logic [22:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Packed view: {wack, load, shift8, shift4, shift2, shift1, underrun, srdat}
  function automatic logic [22:0] model_out(input bit wvalid, input logic [15:0] wdat);
    logic [22:0] v;
    v = '0;
    v[16] = m_under;
    if (m_running) begin
      if (m_pos == 0) begin
        v[21] = 1'b1;
        v[22] = wvalid;
        v[15:0] = wvalid ? wdat : 16'h0000;
      end else begin
        v[17 + m_word_bpp] = 1'b1;
      end
    end
    return v;
  endfunction

  task automatic model_edge(input bit r, input bit hden, input logic [1:0] bpp, input bit wvalid);
    if (r) begin
      m_running = 0; m_pos = 0; m_word_bpp = 0; m_under = 0;
    end else if (!m_running) begin
      if (hden) m_running = 1;
      m_pos = 0;
    end else begin
      if (m_pos == 0) begin
        m_word_bpp = int'(bpp);
        if (!wvalid) m_under = 1;
      end
      if (!hden) begin
        m_running = 0;
        m_pos = 0;
      end else begin
        m_pos = (m_pos + 1) % (16 >> m_word_bpp);
      end
    end
  endtask

  // Driver: one dot clock with the given inputs, checked mid-cycle.
  task automatic cycle(input string tag, input bit r, input bit hden, input logic [1:0] bpp,
                       input bit wvalid, input logic [15:0] wdat);
    logic [22:0] obs;
    @(negedge clk);
    rst = r; sif.hden_i = hden; sif.bpp_i = bpp; sif.wvalid_i = wvalid; sif.wdat_i = wdat;
    #1;
    exp_q.push_back(model_out(wvalid, wdat));
    obs = {sif.wack_o, sif.load_o, sif.shift8_o, sif.shift4_o, sif.shift2_o, sif.shift1_o,
           sif.underrun_o, sif.srdat_o};
    check_val(tag, obs, exp_q.pop_front());
    @(posedge clk);
    model_edge(r, hden, bpp, wvalid);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; sif.hden_i = 1'b0; sif.bpp_i = 2'b00; sif.wvalid_i = 1'b0; sif.wdat_i = '0;
    @(posedge clk);
    model_edge(1'b1, 1'b0, 2'b00, 1'b0);
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    m_running = 0; m_pos = 0; m_word_bpp = 0; m_under = 0;
    rst = 1'b1; sif.hden_i = 1'b0; sif.bpp_i = 2'b00; sif.wvalid_i = 1'b0; sif.wdat_i = '0;
    do_reset();
    cycle("reset_idle", 0, 0, 2'b10, 1, 16'hFFFF);

    // 4bpp continuous, period 4
    for (int i = 0; i < 13; i++) cycle("bpp4_run", 0, 1, 2'b10, 1, 16'h1234);
    cycle("bpp4_stop", 0, 0, 2'b10, 1, 16'h1234);

    // 1bpp continuous, one wack per 16
    for (int i = 0; i < 34; i++) cycle("bpp1_run", 0, 1, 2'b00, 1, 16'hA5A5 + 16'(i));
    cycle("bpp1_stop", 0, 0, 2'b00, 1, 16'h0);

    // 8bpp underrun, sticky past hden fall
    cycle("u8_enter", 0, 1, 2'b11, 1, 16'h0);
    cycle("u8_load_invalid", 0, 1, 2'b11, 0, 16'hBEEF);
    cycle("u8_shift", 0, 1, 2'b11, 1, 16'h1111);
    cycle("u8_load_ok", 0, 1, 2'b11, 1, 16'h2222);
    cycle("u8_hden_fall", 0, 0, 2'b11, 1, 16'h3333);
    for (int i = 0; i < 3; i++) cycle("u8_sticky", 0, 0, 2'b11, 1, 16'h4444);

    // 2bpp, hden dropped on phase 1, then restart with a load
    cycle("d2_enter", 0, 1, 2'b01, 1, 16'h0);
    cycle("d2_load", 0, 1, 2'b01, 1, 16'h5555);
    cycle("d2_drop_ph1", 0, 0, 2'b01, 1, 16'h6666);
    cycle("d2_idle", 0, 0, 2'b01, 1, 16'h7777);
    cycle("d2_reenter", 0, 1, 2'b01, 1, 16'h8888);
    cycle("d2_first_load", 0, 1, 2'b01, 1, 16'h9999);
    for (int i = 0; i < 8; i++) cycle("d2_run", 0, 1, 2'b01, 1, 16'h1357);

    // bpp change mid-word has no effect until the next load
    do_reset();
    cycle("m_enter", 0, 1, 2'b10, 1, 16'h0);
    cycle("m_load4", 0, 1, 2'b10, 1, 16'hCAFE);
    for (int i = 0; i < 3; i++) cycle("m_shift4", 0, 1, 2'b11, 1, 16'hCAFE);
    cycle("m_load8", 0, 1, 2'b11, 1, 16'hF00D);
    cycle("m_shift8", 0, 1, 2'b00, 1, 16'hF00D);
    cycle("m_load_next", 0, 1, 2'b00, 1, 16'hD00F);

    // reset at phase 5 of a 1bpp word with underrun set
    do_reset();
    cycle("r_enter", 0, 1, 2'b00, 0, 16'h0);
    cycle("r_load_under", 0, 1, 2'b00, 0, 16'h0);
    for (int i = 1; i < 5; i++) cycle("r_shift1", 0, 1, 2'b00, 1, 16'h0);
    cycle("r_reset_ph5", 1, 1, 2'b00, 1, 16'h0);
    cycle("r_after_reset", 0, 1, 2'b00, 1, 16'h1);
    cycle("r_restart_load", 0, 1, 2'b00, 1, 16'h2);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit r, h, v;
      r = ($urandom_range(0, 199) == 0);
      h = ($urandom_range(0, 19) != 0);
      v = ($urandom_range(0, 9) != 0);
      cycle("rand", r, h, 2'($urandom_range(0, 3)), v, 16'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Watchdog so the run cannot hang.
  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1);
  end

endmodule
